aes128_encrypt_core: RTL and testbench

Iterative AES-128 encryption engine, the forward-direction counterpart of the AES-128 decryption block. It accepts one 128-bit plaintext and key per request and performs one round per clock, expanding round keys on the fly. It presents the ciphertext on a held output register with a one-cycle done pulse. It sits beside the decryption block under the AES top level and shares its data and key bit ordering.

---
 rtl/aes128_encrypt_core.sv | 163 ++++++++++++++++
 tb/tb_aes128_encrypt_core.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_core.sv
// rtl/aes128_encrypt_core.sv - iterative AES-128 encryption core, one round per clock
// Forward S-box computed as GF(2^8) inverse (x^254) followed by the FIPS-197 affine map.

module aes_sbox_fwd (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_inv;

    // Addition chain 1,2,3,6,12,15,30,60,120,240,252,254 gives the inverse (0 maps to 0)
    always_comb begin
        w_x2   = gf_mul(i_byte, i_byte);
        w_x3   = gf_mul(w_x2, i_byte);
        w_x6   = gf_mul(w_x3, w_x3);
        w_x12  = gf_mul(w_x6, w_x6);
        w_x15  = gf_mul(w_x12, w_x3);
        w_x30  = gf_mul(w_x15, w_x15);
        w_x60  = gf_mul(w_x30, w_x30);
        w_x120 = gf_mul(w_x60, w_x60);
        w_x240 = gf_mul(w_x120, w_x120);
        w_inv  = gf_mul(gf_mul(w_x240, w_x12), w_x2);
        o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end
endmodule

module aes128_encrypt_core (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         encryptEnable,
    input  logic [127:0] key,
    input  logic [127:0] inputData,
    output logic [127:0] outputData,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ROUND = 2'b01
    } fsm_t;

    fsm_t         r_fsm, w_fsm_next;
    logic [127:0] r_state, r_rk, r_out;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic         r_done;
    logic         w_accept, w_step, w_last;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] w_st_b [16];
    logic [7:0] w_sb_b [16];
    logic [7:0] w_sr_b [16];
    logic [7:0] w_mc_b [16];
    logic [7:0] w_rk_b [16];
    logic [7:0] w_ks_b [4];
    wire  [127:0] w_sr, w_mc, w_nk;
    wire  [31:0]  w_sw;
    wire  [31:0]  w_nw0, w_nw1, w_nw2, w_nw3;

    // Byte i lives at [127-8i -: 8]; bytes 4c..4c+3 form column c
    genvar gi, gc, gr;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            assign w_st_b[gi] = r_state[127-8*gi -: 8];
            assign w_rk_b[gi] = r_rk[127-8*gi -: 8];
            aes_sbox_fwd u_sbox (.i_byte(w_st_b[gi]), .o_byte(w_sb_b[gi]));
            assign w_sr[127-8*gi -: 8] = w_sr_b[gi];
            assign w_mc[127-8*gi -: 8] = w_mc_b[gi];
        end
        for (gc = 0; gc < 4; gc++) begin : g_cols
            for (gr = 0; gr < 4; gr++) begin : g_rows
                assign w_sr_b[4*gc+gr] = w_sb_b[4*((gc+gr)%4)+gr];
            end
            assign w_mc_b[4*gc+0] = xt(w_sr_b[4*gc+0]) ^ xt(w_sr_b[4*gc+1]) ^ w_sr_b[4*gc+1]
                                  ^ w_sr_b[4*gc+2] ^ w_sr_b[4*gc+3];
            assign w_mc_b[4*gc+1] = w_sr_b[4*gc+0] ^ xt(w_sr_b[4*gc+1]) ^ xt(w_sr_b[4*gc+2])
                                  ^ w_sr_b[4*gc+2] ^ w_sr_b[4*gc+3];
            assign w_mc_b[4*gc+2] = w_sr_b[4*gc+0] ^ w_sr_b[4*gc+1] ^ xt(w_sr_b[4*gc+2])
                                  ^ xt(w_sr_b[4*gc+3]) ^ w_sr_b[4*gc+3];
            assign w_mc_b[4*gc+3] = xt(w_sr_b[4*gc+0]) ^ w_sr_b[4*gc+0] ^ w_sr_b[4*gc+1]
                                  ^ w_sr_b[4*gc+2] ^ xt(w_sr_b[4*gc+3]);
        end
        // SubWord(RotWord(w3)): w3 is bytes 12..15, rotated to 13,14,15,12
        for (gi = 0; gi < 4; gi++) begin : g_ksbox
            aes_sbox_fwd u_ksbox (.i_byte(w_rk_b[12 + ((gi + 1) % 4)]), .o_byte(w_ks_b[gi]));
            assign w_sw[31-8*gi -: 8] = w_ks_b[gi];
        end
    endgenerate

    assign w_nw0 = r_rk[127:96] ^ w_sw ^ {r_rcon, 24'h0};
    assign w_nw1 = r_rk[95:64] ^ w_nw0;
    assign w_nw2 = r_rk[63:32] ^ w_nw1;
    assign w_nw3 = r_rk[31:0]  ^ w_nw2;
    assign w_nk  = {w_nw0, w_nw1, w_nw2, w_nw3};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = S_IDLE;
        case (r_fsm)
            S_IDLE:  w_fsm_next = encryptEnable ? S_ROUND : S_IDLE;
            S_ROUND: w_fsm_next = (r_round < 4'd10) ? S_ROUND : S_IDLE;
            default: w_fsm_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept = (r_fsm == S_IDLE) && encryptEnable;
        w_step   = (r_fsm == S_ROUND) && (r_round < 4'd10);
        w_last   = (r_fsm == S_ROUND) && !(r_round < 4'd10);
        busy     = (r_fsm == S_ROUND);
    end

    // rcon reaches 8'h36 exactly at round 10, so the final key step reuses r_rcon
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= '0;
            r_rk    <= '0;
            r_out   <= '0;
            r_round <= 4'd0;
            r_rcon  <= 8'h01;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_state <= inputData ^ key;
                r_rk    <= key;
                r_round <= 4'd1;
                r_rcon  <= 8'h01;
            end else if (w_step) begin
                r_state <= w_mc ^ w_nk;
                r_rk    <= w_nk;
                r_round <= r_round + 4'd1;
                r_rcon  <= xt(r_rcon);
            end else if (w_last) begin
                r_out   <= w_sr ^ w_nk;
                r_round <= 4'd0;
                r_rcon  <= 8'h01;
            end
        end
    end

    assign outputData = r_out;
    assign done       = r_done;
endmodule

// File: tb/tb_aes128_encrypt_core.sv
// tb/tb_aes128_encrypt_core.sv - self-checking bench for aes128_encrypt_core

module tb_aes128_encrypt_core;
    logic         clk = 1'b0;
    logic         n_rst;
    logic         encryptEnable;
    logic [127:0] key;
    logic [127:0] inputData;
    logic [127:0] outputData;
    logic         busy;
    logic         done;

    aes128_encrypt_core dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .encryptEnable (encryptEnable),
        .key           (key),
        .inputData     (inputData),
        .outputData    (outputData),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] k;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t         vecs [4];
    logic [127:0] exp_q [$];
    int           tests    = 0;
    int           fails    = 0;
    int           done_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got %h expected no completion", outputData);
            end else begin
                check("ciphertext", outputData, exp_q.pop_front());
            end
        end
    end

    task automatic run_vec(input int idx);
        int edges;
        int busy_cnt;
        key           = vecs[idx].k;
        inputData     = vecs[idx].pt;
        encryptEnable = 1'b1;
        exp_q.push_back(vecs[idx].ct);
        @(posedge clk); #1;
        encryptEnable = 1'b0;
        busy_cnt = busy ? 1 : 0;
        edges    = 0;
        while (edges < 30 && done !== 1'b1) begin
            @(posedge clk); #1;
            edges++;
            if (busy && !done) busy_cnt++;
        end
        check("latency_edges", 128'(edges), 128'd10);
        check("busy_cycles", 128'(busy_cnt), 128'd10);
        check("busy_at_done", 128'(busy), 128'd0);
        @(posedge clk); #1;
        check("done_pulse_width", 128'(done), 128'd0);
        check("output_held", outputData, vecs[idx].ct);
    endtask

    initial begin
        int d0, e, e1, e2, n_done;
        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                    128'h3ad77bb40d7a3660a89ecaf32466ef97};

        n_rst = 1'b0; encryptEnable = 1'b0; key = '0; inputData = '0;
        #12;
        check("reset_output", outputData, 128'h0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) run_vec(i);

        // Busy rejection: new requests and changing inputs mid-run are ignored
        d0 = done_cnt;
        key = vecs[0].k; inputData = vecs[0].pt; encryptEnable = 1'b1;
        exp_q.push_back(vecs[0].ct);
        @(posedge clk); #1;
        encryptEnable = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k >= 2 && k <= 5) begin
                encryptEnable = 1'b1;
                key           = {$urandom, $urandom, $urandom, $urandom};
                inputData     = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                encryptEnable = 1'b0;
            end
        end
        check("busy_reject_done_count", 128'(done_cnt - d0), 128'd1);

        // Back-to-back with encryptEnable held high
        key = vecs[1].k; inputData = vecs[1].pt; encryptEnable = 1'b1;
        exp_q.push_back(vecs[1].ct);
        n_done = 0; e = 0; e1 = 0; e2 = 0;
        while (n_done < 2 && e < 40) begin
            @(posedge clk); #1;
            e++;
            if (n_done == 1 && e == e1 + 1) encryptEnable = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    e1 = e;
                    key = vecs[0].k; inputData = vecs[0].pt;
                    exp_q.push_back(vecs[0].ct);
                end else begin
                    e2 = e;
                end
            end
        end
        encryptEnable = 1'b0;
        check("b2b_first_done_edge", 128'(e1), 128'd11);
        check("b2b_done_spacing", 128'(e2 - e1), 128'd11);

        // Reset mid-run aborts with no done pulse
        key = vecs[1].k; inputData = vecs[1].pt; encryptEnable = 1'b1;
        @(posedge clk); #1;
        encryptEnable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check("midrst_output", outputData, 128'h0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_done", 128'(done), 128'd0);
        @(negedge clk); n_rst = 1'b1;
        d0 = done_cnt;
        repeat (15) @(posedge clk);
        #1;
        check("midrst_no_done", 128'(done_cnt - d0), 128'd0);
        run_vec(1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
